// File: rtl/pingpong_blk_ctrl.sv
// Ping-pong block buffer controller: fills one RAM bank from the input stream
// while the other bank is replayed, in write order, through a 2-entry skid FIFO.
module pingpong_blk_ctrl #(
  parameter int BLK_WORDS = 64,
  parameter int WIDTH     = 12,
  parameter int AW        = $clog2(2 * BLK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       bank_full,
  output logic             ram_cena,
  output logic [AW-1:0]    ram_aa,
  input  logic [WIDTH-1:0] ram_qa,
  output logic             ram_cenb,
  output logic [AW-1:0]    ram_ab,
  output logic [WIDTH-1:0] ram_db
);

  localparam int PW = AW - 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(BLK_WORDS - 1);

  // Handshake rule for both streams: a word moves on a rising clk edge when
  // valid and ready are both high in the cycle before it; valid never waits on ready.

  logic             r_wbank;
  logic [PW-1:0]    r_wptr;
  logic             r_rbank;
  logic [PW-1:0]    r_rptr;
  logic [1:0]       r_bank_full;
  logic             r_rd_pend;
  logic             r_last_q;
  logic [WIDTH-1:0] r_fifo_data0;
  logic [WIDTH-1:0] r_fifo_data1;
  logic             r_fifo_last0;
  logic             r_fifo_last1;
  logic [1:0]       r_occ;

  logic       w_wr_acc;
  logic       w_wr_blk_done;
  logic       w_pop;
  logic [2:0] w_inflight;
  logic [2:0] w_room_limit;
  logic       w_issue;
  logic       w_rd_blk_done;
  logic [1:0] w_bank_full_nxt;

  // ---------------- write side ----------------
  assign in_ready      = !rst && !r_bank_full[r_wbank];
  assign w_wr_acc      = in_valid && in_ready;
  assign w_wr_blk_done = w_wr_acc && (r_wptr == LAST_PTR);

  assign ram_cenb = !w_wr_acc;
  assign ram_ab   = rst ? '0 : {r_wbank, r_wptr};
  assign ram_db   = in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbank <= 1'b0;
      r_wptr  <= '0;
    end else if (w_wr_acc) begin
      if (w_wr_blk_done) begin
        r_wbank <= !r_wbank;
        r_wptr  <= '0;
      end else begin
        r_wptr <= r_wptr + 1'b1;
      end
    end
  end

  // ---------------- read side ----------------
  assign w_pop = out_valid && out_ready;

  // Words already owed to the FIFO (stored + one in flight) must stay below two
  // after this cycle's pop, so an issued read always finds a free slot.
  assign w_inflight    = {1'b0, r_occ} + {2'b00, r_rd_pend};
  assign w_room_limit  = 3'd2 + {2'b00, w_pop};
  assign w_issue       = !rst && r_bank_full[r_rbank] && (w_inflight < w_room_limit);
  assign w_rd_blk_done = w_issue && (r_rptr == LAST_PTR);

  assign ram_cena = !w_issue;
  assign ram_aa   = rst ? '0 : {r_rbank, r_rptr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rbank   <= 1'b0;
      r_rptr    <= '0;
      r_rd_pend <= 1'b0;
      r_last_q  <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      r_last_q  <= w_rd_blk_done;
      if (w_issue) begin
        if (w_rd_blk_done) begin
          r_rbank <= !r_rbank;
          r_rptr  <= '0;
        end else begin
          r_rptr <= r_rptr + 1'b1;
        end
      end
    end
  end

  // ---------------- bank ownership ----------------
  // Set and clear in one cycle always address different banks, so both apply.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_wr_blk_done) w_bank_full_nxt[r_wbank] = 1'b1;
    if (w_rd_blk_done) w_bank_full_nxt[r_rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_bank_full <= 2'b00;
    else     r_bank_full <= w_bank_full_nxt;
  end

  assign bank_full = rst ? 2'b00 : r_bank_full;

  // ---------------- output skid FIFO (entry 0 is the head) ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ        <= 2'd0;
      r_fifo_data0 <= '0;
      r_fifo_data1 <= '0;
      r_fifo_last0 <= 1'b0;
      r_fifo_last1 <= 1'b0;
    end else begin
      case ({r_rd_pend, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_fifo_data0 <= ram_qa;
            r_fifo_last0 <= r_last_q;
          end else begin
            r_fifo_data1 <= ram_qa;
            r_fifo_last1 <= r_last_q;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_fifo_data0 <= r_fifo_data1;
          r_fifo_last0 <= r_fifo_last1;
          r_occ        <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_fifo_data0 <= ram_qa;
            r_fifo_last0 <= r_last_q;
          end else begin
            r_fifo_data0 <= r_fifo_data1;
            r_fifo_last0 <= r_fifo_last1;
            r_fifo_data1 <= ram_qa;
            r_fifo_last1 <= r_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = !rst && (r_occ != 2'd0);
  assign out_data  = r_fifo_data0;
  assign out_last  = out_valid && r_fifo_last0;

endmodule

// File: tb/tb_pingpong_blk_ctrl.sv
// Bench for pingpong_blk_ctrl with a behavioural two-port RAM; a driver pushes
// expected {data,last} words into a queue and a monitor pops them on output.
module tb_pingpong_blk_ctrl;

  localparam int BLK = 64;
  localparam int W   = 12;
  localparam int AW  = $clog2(2 * BLK);
  localparam int EW  = W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [1:0]    bank_full;
  logic          ram_cena;
  logic [AW-1:0] ram_aa;
  logic [W-1:0]  ram_qa;
  logic          ram_cenb;
  logic [AW-1:0] ram_ab;
  logic [W-1:0]  ram_db;

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  logic [W-1:0]  mem [0:2*BLK-1];
  logic [AW-1:0] ram_aq;

  always @(posedge clk) begin
    if (!ram_cena) ram_aq <= ram_aa;
    if (!ram_cenb) mem[ram_ab] <= ram_db;
  end
  assign ram_qa = mem[ram_aq];

  pingpong_blk_ctrl #(.BLK_WORDS(BLK), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .bank_full(bank_full),
    .ram_cena(ram_cena), .ram_aa(ram_aa), .ram_qa(ram_qa),
    .ram_cenb(ram_cenb), .ram_ab(ram_ab), .ram_db(ram_db)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int n_pops = 0;
  int last_acc = 0;
  bit rnd_ready = 1'b0;
  logic [EW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic do_reset(input bit check_vals);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    if (check_vals) begin
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_bank_full", int'(bank_full), 0);
      check("rst_cena", int'(ram_cena), 1);
      check("rst_cenb", int'(ram_cenb), 1);
      check("rst_aa", int'(ram_aa), 0);
      check("rst_ab", int'(ram_ab), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
  endtask

  task automatic send_words(input int base, input int n, input bit rnd_valid, output int n_stall);
    bit acc;
    n_stall = 0;
    for (int i = 0; i < n; i++) begin
      if (rnd_valid) begin
        repeat ($urandom_range(0, 1)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = W'(base + i);
      acc = 1'b0;
      for (int t = 0; t < 2000 && !acc; t++) begin
        @(negedge clk);
        if (in_ready) begin
          acc = 1'b1;
          exp_q.push_back({in_data, (wr_cnt % BLK) == BLK - 1});
          wr_cnt++;
          last_acc = cyc;
        end else begin
          n_stall++;
        end
        @(posedge clk); #1;
      end
      if (!acc) begin
        check("in_accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 8000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_loop();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!ram_cenb) check("wr_to_full_bank", int'(bank_full[ram_ab[AW-1]]), 0);
        if (!ram_cena) check("rd_from_empty_bank", int'(bank_full[ram_aa[AW-1]]), 1);
        if (dut.r_rd_pend)
          check("skid_overflow", int'(dut.r_occ == 2'd2 && !(out_valid && out_ready)), 0);
        if (out_valid && out_ready) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            check("unexpected_output", int'(out_data), -1);
          end else begin
            e = exp_q.pop_front();
            check("out_data", int'(out_data), int'(e[EW-1:1]));
            check("out_last", int'(out_last), int'(e[0]));
          end
        end
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Flags the cycle where bank 1's last write meets bank 0's last read issue.
  task automatic coincidence_check();
    bit found = 1'b0;
    for (int t = 0; t < 600 && !found; t++) begin
      @(negedge clk);
      if (!ram_cenb && ram_ab == AW'(2*BLK-1) && !ram_cena && ram_aa == AW'(BLK-1)) begin
        found = 1'b1;
        check("coinc_bank_full_before", int'(bank_full), 1);
        @(negedge clk);
        check("coinc_bank_full_after", int'(bank_full), 2);
        check("coinc_wr_b0_addr0", int'(!ram_cenb && ram_ab == '0), 1);
      end
    end
    check("coinc_seen", int'(found), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int stalls;
    int first_ov;
    int t63;
    int tr;
    int pops0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    fork
      monitor_loop();
      ready_loop();
      begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
      end
    join_none
    @(posedge clk); #1;

    // reset values and first cycle after reset
    do_reset(1'b1);
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_bank_full", int'(bank_full), 0);
    check("post_rst_cena", int'(ram_cena), 1);
    @(posedge clk); #1;

    // single block 0..63, latency from last accept to first output
    send_words(0, BLK, 1'b0, stalls);
    first_ov = -1;
    for (int t = 0; t < 10 && first_ov < 0; t++) begin
      @(negedge clk);
      if (out_valid) first_ov = cyc;
    end
    check("first_out_latency", first_ov - last_acc, 3);
    @(posedge clk); #1;
    wait_drain("blk1_drain");
    check("blk1_bank_full_idle", int'(bank_full), 0);

    // four continuous blocks, no input bubbles, bank hand-over coincidence
    do_reset(1'b0);
    fork
      send_words(0, 4*BLK, 1'b0, stalls);
      coincidence_check();
    join
    check("cont_in_stalls", stalls, 0);
    wait_drain("cont_drain");

    // both banks fill with the consumer stalled
    do_reset(1'b0);
    out_ready = 1'b0;
    send_words(0, 2*BLK, 1'b0, stalls);
    @(negedge clk);
    check("stall_bank_full", int'(bank_full), 3);
    check("stall_in_ready", int'(in_ready), 0);
    check("stall_out_valid", int'(out_valid), 1);
    check("stall_out_head", int'(out_data), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    t63 = -1;
    tr = -1;
    for (int t = 0; t < 400 && tr < 0; t++) begin
      @(negedge clk);
      if (!ram_cena && ram_aa == AW'(BLK-1) && t63 < 0) t63 = cyc;
      if (in_ready && tr < 0) tr = cyc;
    end
    check("in_ready_rise_after_rd63", tr - t63, 1);
    @(posedge clk); #1;
    wait_drain("stall_drain");

    // random valid / ready over 32 blocks
    rnd_ready = 1'b1;
    send_words(1000, 32*BLK, 1'b1, stalls);
    wait_drain("rand_drain");
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    check("rand_bank_full_idle", int'(bank_full), 0);

    // reset while reading word 30 of the third block
    pops0 = n_pops;
    send_words(500, 3*BLK, 1'b0, stalls);
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk); #1;
      if (n_pops >= pops0 + 2*BLK + 31) break;
    end
    check("mid_read_reached", int'(n_pops >= pops0 + 2*BLK + 31), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_bank_full", int'(bank_full), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    pops0 = n_pops;
    send_words(100, BLK, 1'b0, stalls);
    wait_drain("fresh_drain");
    check("fresh_word_count", n_pops - pops0, BLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
